// File: rtl/pipe_ctrl_unit_if.sv
// Handshake bundle between the datapath (master) and the pipeline sequencer (slave).
interface pipe_ctrl_unit_if #(
  parameter int STAGES = 5
);
  localparam int SW = $clog2(STAGES);

  logic              i_rdy;
  logic              d_req;
  logic              d_rdy;
  logic              load_use;
  logic              hlt_dec;
  logic              redirect_vld;
  logic [SW-1:0]     redirect_src;

  logic              stall_pc;
  logic [STAGES-2:0] stall;
  logic [STAGES-2:0] flush;
  logic [STAGES-1:0] valid;
  logic              redirect_take;
  logic              hlt;
  logic              wdog_err;
  logic [15:0]       stall_cnt;

  modport master (
    output i_rdy, d_req, d_rdy, load_use, hlt_dec, redirect_vld, redirect_src,
    input  stall_pc, stall, flush, valid, redirect_take, hlt, wdog_err, stall_cnt
  );

  modport slave (
    input  i_rdy, d_req, d_rdy, load_use, hlt_dec, redirect_vld, redirect_src,
    output stall_pc, stall, flush, valid, redirect_take, hlt, wdog_err, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipeline sequencer: per-stage valid tracking, stall/flush/bubble arbitration,
// halt draining, D-memory stall watchdog and stall statistics.
module pipe_ctrl_unit #(
  parameter int STAGES    = 5,
  parameter int MEM_STAGE = 3,
  parameter int MAX_STALL = 255,
  parameter int SW        = $clog2(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_unit_if.slave  bus
);
  localparam int WW = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t            state_reg;
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] valid_next;
  logic              valid0_next;
  // halt_pos indexes the pipe register holding the HLT; reaching STAGES-1 means retired
  logic [STAGES-1:0] halt_pos_reg;
  logic              hlt_reg;
  logic              wdog_err_reg;
  logic [WW-1:0]     wdog_cnt_reg;
  logic [15:0]       stall_cnt_reg;

  logic              running;
  logic              dstall;
  logic              lu_hit;
  logic              src_ok;
  logic              src_frozen;
  logic              take;
  logic              resume;
  logic              halt_adv;
  logic              drain_start;
  logic [SW-1:0]     src;
  logic [SW-1:0]     halt_idx;
  logic              stall_pc_c;
  logic [STAGES-2:0] stall_c;
  logic [STAGES-2:0] flush_c;
  logic [STAGES-2:0] take_mask;

  assign src        = bus.redirect_src;
  assign running    = (state_reg != ST_HALTED);
  assign dstall     = running & bus.d_req & valid_reg[MEM_STAGE] & ~bus.d_rdy;
  assign lu_hit     = bus.load_use & valid_reg[1];
  assign src_ok     = (src != '0) && (src <= SW'(STAGES - 2));
  // Stages 0..MEM_STAGE are frozen while the data access is outstanding
  assign src_frozen = dstall && (src <= SW'(MEM_STAGE));
  assign take       = ~rst & running & bus.redirect_vld & src_ok & ~src_frozen;

  always_comb begin
    halt_idx = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (halt_pos_reg[i]) halt_idx = SW'(i);
    end
  end

  assign resume = take && (state_reg == ST_DRAIN) && (src > halt_idx);

  generate
    for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_take_mask
      assign take_mask[gi] = (SW'(gi) < src);
    end
  endgenerate

  always_comb begin
    stall_pc_c = 1'b0;
    stall_c    = '0;
    flush_c    = '0;
    if (rst) begin
      stall_pc_c = 1'b1;
      flush_c    = '1;
    end else if (state_reg == ST_HALTED) begin
      stall_pc_c = 1'b1;
      stall_c    = '1;
    end else begin
      if (dstall) begin
        stall_pc_c               = 1'b1;
        stall_c[MEM_STAGE-1:0]   = '1;
        flush_c[MEM_STAGE]       = 1'b1;
      end else if (!take && lu_hit) begin
        stall_pc_c = 1'b1;
        stall_c[0] = 1'b1;
        flush_c[1] = 1'b1;
      end else if (!take && !bus.i_rdy) begin
        stall_pc_c = 1'b1;
        flush_c[0] = 1'b1;
      end
      if (state_reg == ST_DRAIN) stall_pc_c = 1'b1;
      // An accepted redirect squashes everything younger than its source
      if (take) begin
        flush_c = flush_c | take_mask;
        stall_c = stall_c & ~take_mask;
        if (state_reg == ST_RUN || resume) stall_pc_c = 1'b0;
      end
    end
  end

  always_comb begin
    if (state_reg == ST_HALTED)      valid0_next = valid_reg[0];
    else if (!stall_pc_c)            valid0_next = 1'b1;
    else if (state_reg == ST_DRAIN)  valid0_next = 1'b0;
    else                             valid0_next = valid_reg[0];
  end

  assign valid_next[0] = valid0_next;
  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_valid
      assign valid_next[gi] = flush_c[gi-1] ? 1'b0 :
                              stall_c[gi-1] ? valid_reg[gi] : valid_reg[gi-1];
    end
  endgenerate

  assign halt_adv    = ~|(halt_pos_reg[STAGES-2:0] & stall_c);
  assign drain_start = bus.hlt_dec & valid_reg[1] & ~stall_c[1] & ~flush_c[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      valid_reg     <= '0;
      halt_pos_reg  <= '0;
      hlt_reg       <= 1'b0;
      wdog_err_reg  <= 1'b0;
      wdog_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      valid_reg <= valid_next;

      case (state_reg)
        ST_RUN: begin
          if (drain_start) begin
            state_reg    <= ST_DRAIN;
            halt_pos_reg <= {{(STAGES-2){1'b0}}, 2'b10};
          end
        end
        ST_DRAIN: begin
          if (resume) begin
            state_reg    <= ST_RUN;
            halt_pos_reg <= '0;
          end else if (halt_adv) begin
            halt_pos_reg <= halt_pos_reg << 1;
            if (halt_pos_reg[STAGES-2]) begin
              state_reg <= ST_HALTED;
              hlt_reg   <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_HALTED;
        end
      endcase

      if (dstall) begin
        if (wdog_cnt_reg != WW'(MAX_STALL)) wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
        if (wdog_cnt_reg == WW'(MAX_STALL - 1)) wdog_err_reg <= 1'b1;
      end else begin
        wdog_cnt_reg <= '0;
      end

      if (state_reg == ST_RUN && (stall_pc_c || (|flush_c)) && stall_cnt_reg != 16'hFFFF)
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign bus.stall_pc      = stall_pc_c;
  assign bus.stall         = stall_c;
  assign bus.flush         = flush_c;
  assign bus.valid         = valid_reg;
  assign bus.redirect_take = take;
  assign bus.hlt           = hlt_reg;
  assign bus.wdog_err      = wdog_err_reg;
  assign bus.stall_cnt     = stall_cnt_reg;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit (STAGES=5, MEM_STAGE=3, MAX_STALL=4).
module tb_pipe_ctrl_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.STAGES(5)) bus ();

  pipe_ctrl_unit #(.STAGES(5), .MEM_STAGE(3), .MAX_STALL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  localparam int S_SPC = 0, S_STALL = 1, S_FLUSH = 2, S_VALID = 3,
                 S_TAKE = 4, S_HLT = 5, S_WDOG = 6, S_CNT = 7;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_SPC:   return 32'(bus.stall_pc);
      S_STALL: return 32'(bus.stall);
      S_FLUSH: return 32'(bus.flush);
      S_VALID: return 32'(bus.valid);
      S_TAKE:  return 32'(bus.redirect_take);
      S_HLT:   return 32'(bus.hlt);
      S_WDOG:  return 32'(bus.wdog_err);
      default: return 32'(bus.stall_cnt);
    endcase
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_c(string tag, int sel, logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    comb_q.push_back(e);
  endtask

  task automatic push_r(string tag, int sel, logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    reg_q.push_back(e);
  endtask

  task automatic exp_ctl(string tag, logic spc, logic [3:0] stl, logic [3:0] fl, logic tk);
    push_c({tag, ".stall_pc"}, S_SPC, 32'(spc));
    push_c({tag, ".stall"},    S_STALL, 32'(stl));
    push_c({tag, ".flush"},    S_FLUSH, 32'(fl));
    push_c({tag, ".take"},     S_TAKE, 32'(tk));
  endtask

  task automatic drive(logic ir, logic dq, logic dr, logic lu, logic hd, logic rv, logic [2:0] rs);
    bus.i_rdy = ir; bus.d_req = dq; bus.d_rdy = dr; bus.load_use = lu;
    bus.hlt_dec = hd; bus.redirect_vld = rv; bus.redirect_src = rs;
  endtask

  // Inputs are applied 1 time unit after a rising edge; combinational results are
  // sampled 3 units later, registered results 1 unit after the following edge.
  task automatic step(string name);
    exp_t e;
    #3;
    while (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      check_eq(e.tag, obs(e.sel), e.exp);
    end
    @(posedge clk);
    #1;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      check_eq(e.tag, obs(e.sel), e.exp);
    end
    cyc++;
    $display("cycle %0d %s: valid=%b stall=%b flush=%b hlt=%b wdog=%b cnt=%0d",
             cyc, name, bus.valid, bus.stall, bus.flush, bus.hlt, bus.wdog_err, bus.stall_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 3'd0);
    push_c("rst.stall_pc", S_SPC, 32'd1);
    push_c("rst.flush", S_FLUSH, 32'hF);
    push_r("rst.valid", S_VALID, 32'd0);
    push_r("rst.hlt", S_HLT, 32'd0);
    push_r("rst.wdog", S_WDOG, 32'd0);
    push_r("rst.cnt", S_CNT, 32'd0);
    step("reset");
    rst = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0, 3'd0);
      exp_ctl("fill", 0, 4'b0000, 4'b0000, 0);
      push_r("fill.valid", S_VALID, 32'((1 << (i + 1)) - 1));
      step("fill");
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 3'd0);
    @(posedge clk);
    #1;

    // Free-running fill
    do_reset();
    fill();
    exp_ctl("run", 0, 4'b0000, 4'b0000, 0);
    push_r("run.valid", S_VALID, 32'h1F);
    push_r("run.cnt", S_CNT, 32'd0);
    step("run");

    // D-memory stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0, 3'd0);
      exp_ctl("dstall", 1, 4'b0111, 4'b1000, 0);
      push_r("dstall.valid", S_VALID, 32'b01111);
      step("dstall");
    end
    drive(1, 1, 1, 0, 0, 0, 3'd0);
    exp_ctl("drdy", 0, 4'b0000, 4'b0000, 0);
    push_r("drdy.valid", S_VALID, 32'h1F);
    push_r("drdy.cnt", S_CNT, 32'd3);
    step("d_rdy");

    // Redirect from stage 2, then out-of-range sources
    drive(1, 0, 0, 0, 0, 1, 3'd2);
    exp_ctl("redir2", 0, 4'b0000, 4'b0011, 1);
    push_r("redir2.valid", S_VALID, 32'b11001);
    push_r("redir2.cnt", S_CNT, 32'd4);
    step("redirect src2");
    drive(1, 0, 0, 0, 0, 1, 3'd0);
    exp_ctl("src0", 0, 4'b0000, 4'b0000, 0);
    push_r("src0.valid", S_VALID, 32'b10011);
    step("redirect src0");
    drive(1, 0, 0, 0, 0, 1, 3'd4);
    exp_ctl("src4", 0, 4'b0000, 4'b0000, 0);
    push_r("src4.valid", S_VALID, 32'b00111);
    step("redirect src4");

    // Load-use, I-fetch miss, redirect overriding load-use
    drive(1, 0, 0, 1, 0, 0, 3'd0);
    exp_ctl("lu", 1, 4'b0001, 4'b0010, 0);
    push_r("lu.valid", S_VALID, 32'b01011);
    step("load_use");
    drive(0, 0, 0, 0, 0, 0, 3'd0);
    exp_ctl("irdy0", 1, 4'b0000, 4'b0001, 0);
    push_r("irdy0.valid", S_VALID, 32'b10101);
    step("i_rdy low");
    drive(1, 0, 0, 0, 0, 0, 3'd0);
    exp_ctl("norm", 0, 4'b0000, 4'b0000, 0);
    push_r("norm.valid", S_VALID, 32'b01011);
    step("normal");
    drive(1, 0, 0, 1, 0, 1, 3'd1);
    exp_ctl("lu_take", 0, 4'b0000, 4'b0001, 1);
    push_r("lu_take.valid", S_VALID, 32'b10101);
    step("load_use+redirect");

    // Redirect held off by a D-stall, accepted when the access completes
    do_reset();
    fill();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 0, 1, 3'd3);
      exp_ctl("blk", 1, 4'b0111, 4'b1000, 0);
      push_r("blk.valid", S_VALID, 32'b01111);
      step("redirect blocked");
    end
    drive(1, 1, 1, 0, 0, 1, 3'd3);
    exp_ctl("unblk", 0, 4'b0000, 4'b0111, 1);
    push_r("unblk.valid", S_VALID, 32'b10001);
    step("redirect released");

    // Halt drains and freezes the core
    do_reset();
    fill();
    drive(1, 0, 0, 0, 1, 0, 3'd0);
    exp_ctl("hltdec", 0, 4'b0000, 4'b0000, 0);
    push_r("hltdec.hlt", S_HLT, 32'd0);
    push_r("hltdec.valid", S_VALID, 32'h1F);
    step("hlt_dec");
    drive(1, 0, 0, 0, 0, 0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      exp_ctl("drain", 1, 4'b0000, 4'b0000, 0);
      push_r("drain.hlt", S_HLT, (i == 2) ? 32'd1 : 32'd0);
      step("drain");
    end
    drive(1, 0, 0, 0, 0, 1, 3'd2);
    exp_ctl("halted", 1, 4'b1111, 4'b0000, 0);
    push_r("halted.valid", S_VALID, 32'b11000);
    push_r("halted.hlt", S_HLT, 32'd1);
    push_r("halted.cnt", S_CNT, 32'd0);
    step("halted");

    // HLT on a wrong path: redirect from an older stage resumes fetch
    do_reset();
    fill();
    drive(1, 0, 0, 0, 1, 0, 3'd0);
    exp_ctl("hltdec2", 0, 4'b0000, 4'b0000, 0);
    step("hlt_dec");
    drive(1, 0, 0, 0, 0, 1, 3'd2);
    exp_ctl("resume", 0, 4'b0000, 4'b0011, 1);
    push_r("resume.hlt", S_HLT, 32'd0);
    step("drain redirect");
    drive(1, 0, 0, 0, 0, 0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      exp_ctl("after", 0, 4'b0000, 4'b0000, 0);
      push_r("after.hlt", S_HLT, 32'd0);
      step("resumed");
    end

    // Watchdog: sticky after MAX_STALL consecutive stalls, cleared only by reset
    do_reset();
    fill();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 0, 0, 3'd0);
      exp_ctl("wd", 1, 4'b0111, 4'b1000, 0);
      push_r("wd.wdog", S_WDOG, (i >= 3) ? 32'd1 : 32'd0);
      step("wdog stall");
    end
    drive(1, 1, 1, 0, 0, 0, 3'd0);
    push_r("wd_hold.wdog", S_WDOG, 32'd1);
    push_r("wd_hold.cnt", S_CNT, 32'd5);
    step("wdog release");
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
